// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count n steps; a single step still gets a 1-bit counter.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fa_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder bit cells.
module fa_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum[i]   = x[i] ^ y[i] ^ c_s[i];
        assign c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
    end

    assign cout = c_s[DIGIT];
    // Carry into the top bit of this digit; on the last digit that is the MSB.
    assign cmsb = c_s[DIGIT-1];

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSD first.
module add_sub_serial
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2_min1(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_r;
    state_e           state_n;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [WIDTH-1:0] res_next_s;
    logic [WIDTH-1:0] s_r;
    logic             carry_r;
    logic             co_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic [DIGIT-1:0] sum_s;
    logic             cout_s;
    logic             cmsb_s;
    logic             accept_s;
    logic             last_s;

    fa_digit #(.DIGIT(DIGIT)) u_fa (
        .x    (a_sh_r[DIGIT-1:0]),
        .y    (b_sh_r[DIGIT-1:0]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s),
        .cmsb (cmsb_s)
    );

    // New digit enters at the top so the word is LSD-aligned after N steps.
    assign res_next_s = (res_sh_r >> DIGIT) | (WIDTH'(sum_s) << (WIDTH - DIGIT));

    // Next-state decode plus start-accept and last-step strobes.
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_n  = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    state_n = DONE;
                    last_s  = 1'b1;
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_n  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n == RUN);
            done_r  <= (state_n == DONE);
        end
    end

    // Operand/result shift registers, carry and step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= CW'(0);
        end else if (accept_s) begin
            // Subtract is a + ~b + ~ci, so invert b and the carry once at entry.
            a_sh_r   <= a;
            b_sh_r   <= b ^ {WIDTH{sub}};
            res_sh_r <= {WIDTH{1'b0}};
            carry_r  <= ci ^ sub;
            cnt_r    <= CW'(0);
        end else if (state_r == RUN) begin
            a_sh_r   <= a_sh_r >> DIGIT;
            b_sh_r   <= b_sh_r >> DIGIT;
            res_sh_r <= res_next_s;
            carry_r  <= cout_s;
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    // Result registers, updated only on the final step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_r   <= {WIDTH{1'b0}};
            co_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (last_s) begin
            s_r   <= res_next_s;
            co_r  <= cout_s;
            ovf_r <= cmsb_s ^ cout_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign co   = co_r;
    assign ovf  = ovf_r;

endmodule
